// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow memory port between I_cache and D_cache, fixed D priority with an I starvation override; define MEM_ARB_RR_EN to alternate simultaneous requests
module mem_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_req, d_req, starved, grant, done, pick_i;
  assign i_req   = i_read | i_write;
  assign d_req   = d_read | d_write;
  assign starved = starve_q == LIMIT;
  assign grant   = state_q == IDLE && (i_req || d_req);
  assign done    = (state_q == GNT_I || state_q == GNT_D) && mem_ready;
`ifdef MEM_ARB_RR_EN
  logic last_gnt_q;
  // remember which side won the latest grant (1 = I) so a tie goes to the other side
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_gnt_q <= 1'b0;
    else if (grant) last_gnt_q <= pick_i;
  assign pick_i = i_req && (!d_req || starved || !last_gnt_q);
`else
  assign pick_i = i_req && (!d_req || starved);
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: RESP always falls back to IDLE so a stale request is never re-granted
  always_comb begin
    state_d = state_q;
    if (grant) state_d = pick_i ? GNT_I : GNT_D;
    else if (done) state_d = RESP;
    else if (state_q == RESP) state_d = IDLE;
  end
  // next values of the registered outputs and the starvation counter
  always_comb begin
    starve_d    = starve_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    if (grant) begin
      mem_read_d  = pick_i ? i_read  : d_read;
      mem_write_d = pick_i ? i_write : d_write;
      mem_addr_d  = pick_i ? i_addr  : d_addr;
      mem_wdata_d = pick_i ? i_wdata : d_wdata;
      starve_d    = pick_i ? 4'd0 : (i_req && !starved) ? starve_q + 4'd1 : starve_q;
    end
    if (done) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      i_ready_d   = state_q == GNT_I;
      d_ready_d   = state_q == GNT_D;
      i_rdata_d   = (state_q == GNT_I && mem_read_q) ? mem_rdata : i_rdata_q;
      d_rdata_d   = (state_q == GNT_D && mem_read_q) ? mem_rdata : d_rdata_q;
    end
  end
  // output and counter registers; reset drops the memory request immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with STARVE_LIMIT=2 and a latency-configurable memory model
module tb_mem_arbiter;
  typedef struct {
    bit           side;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } txn_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_read = 0, i_write = 0, d_read = 0, d_write = 0;
  logic [27:0] i_addr = '0, d_addr = '0;
  logic [127:0] i_wdata = '0, d_wdata = '0;
  logic [127:0] i_rdata, d_rdata, mem_wdata, mem_rdata = '0;
  logic i_ready, d_ready, mem_read, mem_write;
  logic [27:0] mem_addr;
  logic rsp_rdy = 0, poke = 0, mem_en = 1;
  int lat_cnt = 0, mem_lat = 4;
  int vectors = 0, errors = 0;
  txn_t gnt_q[$], rsp_q[$];
  txn_t cur, e, r;
  logic [127:0] exp_rd [2];
  bit was_active = 0, prev_rdy = 0, active;

  mem_arbiter #(.ADDR_W(28), .LINE_W(128), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(rsp_rdy | poke)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_for(input logic [27:0] a);
    return {4{4'hA, a}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void expect_gnt(input bit side, input bit wr, input logic [27:0] a, input logic [127:0] w);
    txn_t t;
    t.side = side; t.wr = wr; t.addr = a; t.wdata = w;
    gnt_q.push_back(t);
  endfunction

  task automatic drop(input bit side);
    if (side) begin i_read = 0; i_write = 0; end
    else begin d_read = 0; d_write = 0; end
  endtask

  task automatic req(input bit side, input bit wr, input logic [27:0] a, input logic [127:0] w);
    if (side) begin i_read = !wr; i_write = wr; i_addr = a; i_wdata = w; end
    else begin d_read = !wr; d_write = wr; d_addr = a; d_wdata = w; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (side ? i_ready : d_ready) begin
        drop(side);
        return;
      end
    end
    chk(side ? "i_timeout" : "d_timeout", side ? i_ready : d_ready, 1'b1);
    drop(side);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_read"}, mem_read, 1'b0);
    chk({tag, "_mem_write"}, mem_write, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, '0);
    chk({tag, "_ready"}, {i_ready, d_ready}, '0);
  endtask

  // memory model: answers after mem_lat+1 cycles, garbage on rdata otherwise
  initial forever begin
    @(negedge clk);
    rsp_rdy = 0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (rst_n && mem_en && (mem_read | mem_write)) begin
      if (lat_cnt == mem_lat) begin
        rsp_rdy = 1;
        mem_rdata = line_for(mem_addr);
        lat_cnt = 0;
      end else lat_cnt++;
    end else lat_cnt = 0;
  end

  // monitor: pops expected grants as transactions start, checks the frozen bus and the ready pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_q.delete();
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      was_active = 0;
      prev_rdy = 0;
    end else begin
      active = mem_read | mem_write;
      if (active && !was_active) begin
        if (gnt_q.size() == 0) chk("gnt_expected", active, 1'b0);
        else begin
          e = gnt_q.pop_front();
          chk("gnt_mem_read", mem_read, !e.wr);
          chk("gnt_mem_write", mem_write, e.wr);
          chk("gnt_mem_addr", mem_addr, e.addr);
          if (e.wr) chk("gnt_mem_wdata", mem_wdata, e.wdata);
          cur = e;
          rsp_q.push_back(e);
        end
      end else if (active) begin
        chk("frozen_addr", mem_addr, cur.addr);
        if (cur.wr) chk("frozen_wdata", mem_wdata, cur.wdata);
      end
      if (i_ready | d_ready) begin
        chk("rdy_exclusive", i_ready & d_ready, 1'b0);
        chk("rdy_pulse", prev_rdy, 1'b0);
        chk("rdy_mem_idle", active, 1'b0);
        if (rsp_q.size() == 0) chk("rdy_expected", i_ready | d_ready, 1'b0);
        else begin
          r = rsp_q.pop_front();
          chk("rdy_side", i_ready, r.side);
          if (!r.wr) exp_rd[r.side] = line_for(r.addr);
          if (r.side) chk("i_rdata", i_rdata, exp_rd[1]);
          else chk("d_rdata", d_rdata, exp_rd[0]);
        end
      end
      prev_rdy = i_ready | d_ready;
      was_active = active;
    end
  end

  initial begin
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1;
    @(negedge clk);
    // warm-up read so the reset has something to clear
    expect_gnt(0, 0, 28'h0000040, '0);
    req(0, 0, 28'h0000040, '0);
    @(negedge clk);
    // reset in the middle of a D read
    expect_gnt(0, 0, 28'h0000050, '0);
    mem_en = 0;
    d_read = 1; d_addr = 28'h0000050;
    repeat (3) @(negedge clk);
    chk("pre_reset_mem_read", mem_read, 1'b1);
    #2 rst_n = 0;
    #1 chk_reset_outputs("async_rst");
    d_read = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    mem_en = 1;
    @(negedge clk);
    expect_gnt(0, 0, 28'h0000060, '0);
    req(0, 0, 28'h0000060, '0);
    @(negedge clk);
    // single I read, memory request one cycle after the request
    mem_lat = 4;
    expect_gnt(1, 0, 28'h0000010, '0);
    fork
      req(1, 0, 28'h0000010, '0);
      begin @(negedge clk); chk("i_first_cycle", mem_read, 1'b1); end
    join
    @(negedge clk);
    // simultaneous I read and D write: D first
    mem_lat = 2;
    expect_gnt(0, 1, 28'h0000070, {4{32'hDEADBEEF}});
    expect_gnt(1, 0, 28'h0000080, '0);
    fork
      req(0, 1, 28'h0000070, {4{32'hDEADBEEF}});
      req(1, 0, 28'h0000080, '0);
    join
    @(negedge clk);
    // D address changes while granted; bus must stay frozen
    mem_lat = 5;
    expect_gnt(0, 0, 28'h0000090, '0);
    fork
      req(0, 0, 28'h0000090, '0);
      begin repeat (2) @(negedge clk); #1 d_addr = 28'h0ABCDEF; end
    join
    @(negedge clk);
    // starvation: I held while D keeps re-requesting
    mem_lat = 1;
`ifdef MEM_ARB_RR_EN
    expect_gnt(1, 0, 28'h0000300, '0);
    for (int k = 0; k < 3; k++) expect_gnt(0, 0, 28'(28'h400 + k), '0);
`else
    expect_gnt(0, 0, 28'h0000400, '0);
    expect_gnt(0, 0, 28'h0000401, '0);
    expect_gnt(1, 0, 28'h0000300, '0);
    expect_gnt(0, 0, 28'h0000402, '0);
`endif
    fork
      req(1, 0, 28'h0000300, '0);
      for (int k = 0; k < 3; k++) req(0, 0, 28'(28'h400 + k), '0);
    join
    @(negedge clk);
    // both sides requesting back-to-back
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      expect_gnt(1, 0, 28'(28'h100 + k), '0);
      expect_gnt(0, k[0], 28'(28'h200 + k), {4{32'(32'hD0000000 + k)}});
    end
`else
    expect_gnt(0, 0, 28'h0000200, {4{32'hD0000000}});
    expect_gnt(0, 1, 28'h0000201, {4{32'hD0000001}});
    expect_gnt(1, 0, 28'h0000100, '0);
    expect_gnt(0, 0, 28'h0000202, {4{32'hD0000002}});
    expect_gnt(1, 0, 28'h0000101, '0);
    expect_gnt(1, 0, 28'h0000102, '0);
`endif
    fork
      for (int k = 0; k < 3; k++) req(1, 0, 28'(28'h100 + k), '0);
      for (int k = 0; k < 3; k++) req(0, k[0], 28'(28'h200 + k), {4{32'(32'hD0000000 + k)}});
    join
    repeat (2) @(negedge clk);
    // stray mem_ready while idle is ignored
    poke = 1;
    @(negedge clk);
    poke = 0;
    @(negedge clk);
    chk("idle_rdy_ignored", {i_ready, d_ready, mem_read, mem_write}, '0);
    expect_gnt(0, 1, 28'h0000500, {4{32'h12345678}});
    req(0, 1, 28'h0000500, {4{32'h12345678}});
    repeat (3) @(negedge clk);
    chk("gnt_q_drained", gnt_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
